// File: rtl/selector41_pkg.sv
// ---------------------------------------------------------------------------
// selector41_pkg
// Shared definitions for the 4-channel scanning selector:
//   state_t / IDLE / SCAN : controller state encoding
//   NUM_CH                : number of scanned channels
//   DWELL_W               : width of the dwell counter
//   chSel_t               : 2-bit channel code
//   nextLowChannel()      : round-robin search used by the skip-idle build
// ---------------------------------------------------------------------------
package selector41_pkg;

    localparam int NUM_CH  = 4;
    localparam int DWELL_W = 8;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t SCAN = 1'b1;

    typedef logic [1:0] chSel_t;

    // First channel after cur (cur+1, cur+2, ... wrapping, cur itself last)
    // whose active-low line is asserted; plain +1 when no line is low.
    // Scanned from the farthest offset down so the nearest hit is kept.
    function automatic chSel_t nextLowChannel(input chSel_t cur,
                                              input logic [NUM_CH-1:0] ch);
        chSel_t cand;
        nextLowChannel = cur + 2'd1;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = cur + 2'(k);
            if (!ch[cand]) begin
                nextLowChannel = cand;
            end
        end
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// ---------------------------------------------------------------------------
// dwell_counter
// Counts 0..iTerm and wraps to 0; clear has priority over hold.
// Ports:
//   iClk   : clock, rising edge
//   iRst   : asynchronous active-high reset
//   iClr   : synchronous clear to 0
//   iHold  : freeze the count
//   iTerm  : terminal count value
//   oTerm  : high while the count equals iTerm
// ---------------------------------------------------------------------------
module dwell_counter
    import selector41_pkg::*;
(
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iClr,
    input  logic               iHold,
    input  logic [DWELL_W-1:0] iTerm,
    output logic               oTerm
);

    logic [DWELL_W-1:0] count;

    assign oTerm = (count == iTerm);

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            count <= '0;
        end else if (iClr) begin
            count <= '0;
        end else if (!iHold) begin
            count <= oTerm ? '0 : count + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/selector41_scan.sv
// ---------------------------------------------------------------------------
// selector41_scan
// Scans four active-low channel lines, dwelling DWELL_CYCLES clocks on each,
// and forwards the selected line (one cycle late) on oZ.
// Build option: define SELECTOR41_SKIP_IDLE_EN to advance only to channels
// whose line is low (round robin); otherwise plain 0-1-2-3 rotation.
// Ports:
//   iClk            : clock, rising edge
//   iRst            : asynchronous active-high reset
//   iC0..iC3        : active-low channel lines, idle 1
//   iEn             : scan enable
//   iHold           : freeze the current slot
//   oZ              : registered selected line, idle 1
//   oS1, oS0        : current channel code (oS1 = MSB)
//   oSlot           : strobe on the last cycle of a slot
//   oFrame          : strobe on a slot end that closes a frame
// ---------------------------------------------------------------------------
module selector41_scan
    import selector41_pkg::*;
#(
    parameter int DWELL_CYCLES = 4
)
(
    input  logic iClk,
    input  logic iRst,
    input  logic iC0,
    input  logic iC1,
    input  logic iC2,
    input  logic iC3,
    input  logic iEn,
    input  logic iHold,
    output logic oZ,
    output logic oS1,
    output logic oS0,
    output logic oSlot,
    output logic oFrame
);

    localparam logic [DWELL_W-1:0] TERM = DWELL_W'(DWELL_CYCLES - 1);

    state_t            state;
    chSel_t            sel;
    chSel_t            nextSel;
    logic [NUM_CH-1:0] ch;
    logic              counting;
    logic              atTerm;
    logic              frameHit;

    assign ch = {iC3, iC2, iC1, iC0};

    // Dropping iEn ends the scan on the coming edge, so no strobe is
    // emitted in that cycle even if the count is terminal.
    assign counting = (state == SCAN) && iEn;
    assign oSlot    = counting && !iHold && atTerm;
    assign oFrame   = oSlot && frameHit;
    assign oS1      = sel[1];
    assign oS0      = sel[0];

`ifdef SELECTOR41_SKIP_IDLE_EN
    assign nextSel  = nextLowChannel(sel, ch);
    // A frame closes whenever the code fails to increase.
    assign frameHit = (nextSel <= sel);
`else
    assign nextSel  = sel + 2'd1;
    assign frameHit = (sel == 2'b11);
`endif

    dwell_counter uCounter (
        .iClk  (iClk),
        .iRst  (iRst),
        .iClr  (!counting),
        .iHold (iHold),
        .iTerm (TERM),
        .oTerm (atTerm)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
            sel   <= '0;
            oZ    <= 1'b1;
        end else if (!iEn) begin
            state <= IDLE;
            sel   <= '0;
            oZ    <= 1'b1;
        end else begin
            state <= SCAN;
            // Sample the line selected before this edge; sel is 0 in IDLE,
            // so the first SCAN cycle shows channel 0.
            oZ    <= ch[sel];
            if (oSlot) begin
                sel <= nextSel;
            end
        end
    end

endmodule

// File: tb/tb_selector41_scan.sv
// ---------------------------------------------------------------------------
// tb_selector41_scan
// Drives a DWELL_CYCLES=4 and a DWELL_CYCLES=1 instance from shared inputs
// and compares both against a behavioural model every cycle, plus directed
// literal checks of the documented scenarios.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_selector41_scan;

    logic iClk = 1'b0;
    logic iRst, iC0, iC1, iC2, iC3, iEn, iHold;

    logic z4, s14, s04, slot4, frame4;
    logic z1, s11, s01, slot1, frame1;

    always #5 iClk = ~iClk;

    selector41_scan #(.DWELL_CYCLES(4)) u4 (
        .iClk(iClk), .iRst(iRst), .iC0(iC0), .iC1(iC1), .iC2(iC2), .iC3(iC3),
        .iEn(iEn), .iHold(iHold), .oZ(z4), .oS1(s14), .oS0(s04),
        .oSlot(slot4), .oFrame(frame4)
    );

    selector41_scan #(.DWELL_CYCLES(1)) u1 (
        .iClk(iClk), .iRst(iRst), .iC0(iC0), .iC1(iC1), .iC2(iC2), .iC3(iC3),
        .iEn(iEn), .iHold(iHold), .oZ(z1), .oS1(s11), .oS0(s01),
        .oSlot(slot1), .oFrame(frame1)
    );

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: index 0 = DWELL 4 instance, index 1 = DWELL 1.
    // ------------------------------------------------------------------
    int dwell [2] = '{4, 1};
    bit mScan [2] = '{0, 0};
    int mCnt  [2] = '{0, 0};
    int mSel  [2] = '{0, 0};
    bit mZ    [2] = '{1, 1};

    function automatic int nextCh(input int s, input logic [3:0] c);
`ifdef SELECTOR41_SKIP_IDLE_EN
        for (int k = 1; k <= 4; k++) begin
            if (c[(s + k) % 4] == 1'b0) return (s + k) % 4;
        end
`endif
        return (s + 1) % 4;
    endfunction

    always @(posedge iClk or posedge iRst) begin
        logic [3:0] c;
        c = {iC3, iC2, iC1, iC0};
        for (int k = 0; k < 2; k++) begin
            if (iRst || !iEn) begin
                mScan[k] = 1'b0;
                mCnt[k]  = 0;
                mSel[k]  = 0;
                mZ[k]    = 1'b1;
            end else begin
                mZ[k] = c[mSel[k]];
                if (mScan[k] && !iHold) begin
                    if (mCnt[k] == dwell[k] - 1) begin
                        mSel[k] = nextCh(mSel[k], c);
                        mCnt[k] = 0;
                    end else begin
                        mCnt[k]++;
                    end
                end
                mScan[k] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare on the falling edge.
    // ------------------------------------------------------------------
    bit chkOn = 1'b0;

    always @(negedge iClk) begin
        logic [3:0] c;
        int  dz, ds, dslot, dframe, ns;
        bit  es, ef;
        if (chkOn) begin
            c = {iC3, iC2, iC1, iC0};
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin
                    dz = int'(z4); ds = int'({s14, s04});
                    dslot = int'(slot4); dframe = int'(frame4);
                end else begin
                    dz = int'(z1); ds = int'({s11, s01});
                    dslot = int'(slot1); dframe = int'(frame1);
                end
                es = !iRst && mScan[k] && iEn && !iHold && (mCnt[k] == dwell[k] - 1);
                ns = nextCh(mSel[k], c);
`ifdef SELECTOR41_SKIP_IDLE_EN
                ef = es && (ns <= mSel[k]);
`else
                ef = es && (mSel[k] == 3);
`endif
                check($sformatf("model_z[%0d]", k),     dz,     int'(mZ[k]));
                check($sformatf("model_sel[%0d]", k),   ds,     mSel[k]);
                check($sformatf("model_slot[%0d]", k),  dslot,  int'(es));
                check($sformatf("model_frame[%0d]", k), dframe, int'(ef));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 ns after each rising edge.
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge iClk);
        #2;
    endtask

    // One IDLE cycle, then enable; returns in the first SCAN cycle (j=0).
    task automatic restart();
        iEn = 1'b0;
        cyc();
        iEn = 1'b1;
        cyc();
    endtask

    initial begin
        iRst = 1'b1; iEn = 1'b0; iHold = 1'b0;
        {iC3, iC2, iC1, iC0} = 4'hF;
        chkOn = 1'b1;
        repeat (3) cyc();
        #1;
        check("rst_z",     int'(z4), 1);
        check("rst_sel",   int'({s14, s04}), 0);
        check("rst_slot",  int'(slot4), 0);
        check("rst_frame", int'(frame4), 0);
        iRst = 1'b0;
        cyc();
        check("idle_sel", int'({s14, s04}), 0);
        check("idle_z",   int'(z4), 1);

        // Plain scan, all lines idle: 4 cycles per slot, frame once per 16.
        iEn = 1'b1;
        cyc();
        for (int j = 0; j < 20; j++) begin
            #1;
            check("scan_sel",   int'({s14, s04}), (j / 4) % 4);
            check("scan_slot",  int'(slot4), int'(j % 4 == 3));
            check("scan_frame", int'(frame4), int'(j == 15));
            check("scan_z",     int'(z4), 1);
            check("scan1_slot", int'(slot1), 1);
            cyc();
        end

`ifdef SELECTOR41_SKIP_IDLE_EN
        // Only channels 1 and 3 low: 0 -> 1 -> 3 -> 1 ...
        iC1 = 1'b0; iC3 = 1'b0;
        restart();
        repeat (5) cyc();
        check("skip_sel_j5", int'({s14, s04}), 1);
        repeat (4) cyc();
        check("skip_sel_j9", int'({s14, s04}), 3);
        repeat (2) cyc();
        check("skip_frame_j11", int'(frame4), 1);
        repeat (2) cyc();
        check("skip_sel_j13", int'({s14, s04}), 1);
        iC1 = 1'b1; iC3 = 1'b1;
`else
        // Channel 2 low: oZ low during the 4 cycles after select=10.
        iC2 = 1'b0;
        restart();
        repeat (8) cyc();
        #1; check("c2_z_j8", int'(z4), 1);
        cyc();
        #1; check("c2_z_j9", int'(z4), 0);
        repeat (3) cyc();
        #1; check("c2_z_j12", int'(z4), 0);
        cyc();
        #1; check("c2_z_j13", int'(z4), 1);
        iC2 = 1'b1;
`endif

        // Hold for 3 cycles at counter=3 on channel 01.
        restart();
        repeat (7) cyc();
        iHold = 1'b1;
        #1;
        check("hold_slot", int'(slot4), 0);
        check("hold_frame", int'(frame4), 0);
        check("hold_sel",  int'({s14, s04}), 1);
        repeat (2) begin
            cyc();
            #1;
            check("hold_sel",  int'({s14, s04}), 1);
            check("hold_slot", int'(slot4), 0);
        end
        cyc();
        iHold = 1'b0;
        #1;
        check("hold_release_slot", int'(slot4), 1);
        check("hold_release_sel",  int'({s14, s04}), 1);
        cyc();
        check("hold_next_sel", int'({s14, s04}), 2);

        // Asynchronous reset mid-slot on channel 11.
        iC3 = 1'b0;
        restart();
        repeat (13) cyc();
        #1;
        check("pre_rst_sel", int'({s14, s04}), 3);
        check("pre_rst_z",   int'(z4), 0);
        iRst = 1'b1;
        #1;
        check("async_rst_z",     int'(z4), 1);
        check("async_rst_sel",   int'({s14, s04}), 0);
        check("async_rst_slot",  int'(slot4), 0);
        check("async_rst_frame", int'(frame4), 0);
        cyc();
        iRst = 1'b0;
        iC3 = 1'b1;
        cyc();
        check("post_rst_sel", int'({s14, s04}), 0);
        repeat (3) cyc();
        check("post_rst_slot", int'(slot4), 1);
        check("post_rst_sel3", int'({s14, s04}), 0);

        // Enable dropped at counter=2 on channel 10.
        restart();
        repeat (10) cyc();
        iEn = 1'b0;
        #1;
        check("drop_slot",  int'(slot4), 0);
        check("drop_frame", int'(frame4), 0);
        cyc();
        check("drop_sel",   int'({s14, s04}), 0);
        check("drop_z",     int'(z4), 1);
        check("drop_slot2", int'(slot4), 0);

        // Randomized traffic against the model.
        iEn = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            {iC3, iC2, iC1, iC0} = 4'($urandom_range(0, 15));
            iHold = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) iEn = ~iEn;
            else if (!iEn && $urandom_range(0, 3) == 0) iEn = 1'b1;
            if ($urandom_range(0, 399) == 0) begin
                iRst = 1'b1;
                #2;
                iRst = 1'b0;
            end
            cyc();
        end

        chkOn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
